// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and the memory-stage FSM state type.
// Store lane helpers live here so decode and data shaping stay in one place.
package riscv_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         F3_B:    store_be = 4'b0001 << a;
         F3_H:    store_be = a[1] ? 4'b1100 : 4'b0011;
         default: store_be = 4'b1111;
      endcase
   endfunction

   // Narrow stores replicate across every lane so the memory only needs the byte enables.
   function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         F3_B:    store_wdata = {4{d[7:0]}};
         F3_H:    store_wdata = {2{d[15:0]}};
         default: store_wdata = d;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a loaded word and sign- or zero-extends it.
module load_extend
   import riscv_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] value
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (addr)
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         2'd3:    byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    value = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    value = {{16{half_sel[15]}}, half_sel};
         F3_BU:   value = {24'd0, byte_sel};
         F3_HU:   value = {16'd0, half_sel};
         default: value = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack port, stalls while busy.
// Build option MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into error write-backs.
module mem_stage
   import riscv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] iw_in,
   input  logic [31:0] alu_in,
   input  logic [31:0] rs2_data_in,
   input  logic        wb_en_in,
   input  logic [4:0]  wb_reg_in,
   output logic        stall_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid_out,
   output logic [31:0] pc_out,
   output logic [31:0] iw_out,
   output logic        wb_en_out,
   output logic [4:0]  wb_reg_out,
   output logic [31:0] wb_data_out,
   output logic        err_out,
   output logic        df_mem_enable,
   output logic [4:0]  df_mem_reg,
   output logic [31:0] df_mem_data
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_reg, state_next;
   logic [7:0]  cnt_reg;
   logic [1:0]  addr_lo_reg;
   logic        wb_en_pend_reg;
   logic [4:0]  wb_reg_pend_reg;
   logic        dmem_req_reg, dmem_we_reg;
   logic [3:0]  dmem_be_reg;
   logic [31:0] dmem_addr_reg, dmem_wdata_reg;
   logic        wb_valid_reg, wb_en_reg, err_reg;
   logic [31:0] pc_reg, iw_reg, wb_data_reg;
   logic [4:0]  wb_reg_reg;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        is_load, is_store, is_bad, trap, mem_go, timeout_hit;
   logic [31:0] load_value;

   assign opcode   = iw_in[6:0];
   assign funct3   = iw_in[14:12];
   assign is_load  = (opcode == OPC_LOAD) && (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   assign is_store = (opcode == OPC_STORE) && (funct3 inside {F3_B, F3_H, F3_W});
   assign is_bad   = ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) && !is_load && !is_store;

`ifdef MEM_MISALIGN_TRAP_EN
   assign trap = (is_load || is_store) &&
                 (((funct3[1:0] == 2'b01) && alu_in[0]) ||
                  ((funct3[1:0] == 2'b10) && (alu_in[1:0] != 2'b00)));
`else
   assign trap = 1'b0;
`endif

   assign mem_go      = (is_load || is_store) && !trap;
   assign timeout_hit = (cnt_reg == TIMEOUT_LAST);

   load_extend u_load_extend (
      .rdata  (dmem_rdata),
      .addr   (addr_lo_reg),
      .funct3 (iw_reg[14:12]),
      .value  (load_value)
   );

   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      stall_out  = 1'b0;
      case (state_reg)
         IDLE: if (ex_valid_in && mem_go) state_next = BUSY;
         BUSY: begin
            stall_out = 1'b1;
            if (dmem_ack || timeout_hit) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg         <= '0;
         addr_lo_reg     <= '0;
         wb_en_pend_reg  <= 1'b0;
         wb_reg_pend_reg <= '0;
         dmem_req_reg    <= 1'b0;
         dmem_we_reg     <= 1'b0;
         dmem_be_reg     <= '0;
         dmem_addr_reg   <= '0;
         dmem_wdata_reg  <= '0;
         wb_valid_reg    <= 1'b0;
         wb_en_reg       <= 1'b0;
         err_reg         <= 1'b0;
         pc_reg          <= '0;
         iw_reg          <= '0;
         wb_data_reg     <= '0;
         wb_reg_reg      <= '0;
      end else begin
         wb_valid_reg <= 1'b0;
         err_reg      <= 1'b0;
         case (state_reg)
            IDLE: begin
               cnt_reg <= '0;
               if (ex_valid_in) begin
                  pc_reg <= pc_in;
                  iw_reg <= iw_in;
                  if (mem_go) begin
                     dmem_req_reg    <= 1'b1;
                     dmem_we_reg     <= is_store;
                     dmem_be_reg     <= is_store ? store_be(funct3, alu_in[1:0]) : 4'b1111;
                     dmem_addr_reg   <= {alu_in[31:2], 2'b00};
                     dmem_wdata_reg  <= is_store ? store_wdata(funct3, rs2_data_in) : 32'd0;
                     addr_lo_reg     <= alu_in[1:0];
                     wb_en_pend_reg  <= wb_en_in && is_load;
                     wb_reg_pend_reg <= wb_reg_in;
                  end else begin
                     // Non-memory, malformed and trapped instructions all retire next cycle.
                     wb_valid_reg <= 1'b1;
                     wb_en_reg    <= wb_en_in && !is_bad && !trap;
                     wb_reg_reg   <= wb_reg_in;
                     wb_data_reg  <= trap ? 32'd0 : alu_in;
                     err_reg      <= trap;
                  end
               end
            end
            BUSY: begin
               cnt_reg <= cnt_reg + 8'd1;
               if (dmem_ack) begin
                  dmem_req_reg <= 1'b0;
                  wb_valid_reg <= 1'b1;
                  wb_en_reg    <= wb_en_pend_reg;
                  wb_reg_reg   <= wb_reg_pend_reg;
                  wb_data_reg  <= dmem_we_reg ? 32'd0 : load_value;
               end else if (timeout_hit) begin
                  dmem_req_reg <= 1'b0;
                  wb_valid_reg <= 1'b1;
                  wb_en_reg    <= 1'b0;
                  wb_reg_reg   <= wb_reg_pend_reg;
                  wb_data_reg  <= 32'd0;
                  err_reg      <= 1'b1;
               end
            end
            default: cnt_reg <= '0;
         endcase
      end
   end

   assign dmem_req      = dmem_req_reg;
   assign dmem_we       = dmem_we_reg;
   assign dmem_be       = dmem_be_reg;
   assign dmem_addr     = dmem_addr_reg;
   assign dmem_wdata    = dmem_wdata_reg;
   assign wb_valid_out  = wb_valid_reg;
   assign pc_out        = pc_reg;
   assign iw_out        = iw_reg;
   assign wb_en_out     = wb_en_reg;
   assign wb_reg_out    = wb_reg_reg;
   assign wb_data_out   = wb_data_reg;
   assign err_out       = err_reg;
   assign df_mem_enable = wb_valid_reg && wb_en_reg && (wb_reg_reg != 5'd0);
   assign df_mem_reg    = wb_reg_reg;
   assign df_mem_data   = wb_data_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Randomised scoreboard bench for mem_stage: driver plays execute stage and data memory,
// monitor pops expected write-backs whenever wb_valid_out is seen.
module tb_mem_stage;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ex_valid_in = 1'b0;
   logic [31:0] pc_in = '0, iw_in = '0, alu_in = '0, rs2_data_in = '0;
   logic        wb_en_in = 1'b0;
   logic [4:0]  wb_reg_in = '0;
   logic        stall_out, dmem_req, dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        wb_valid_out, wb_en_out, err_out, df_mem_enable;
   logic [31:0] pc_out, iw_out, wb_data_out, df_mem_data;
   logic [4:0]  wb_reg_out, df_mem_reg;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc, iw, data;
      logic [4:0]  rd;
      logic        en, err, cmp_reg, cmp_data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .ex_valid_in(ex_valid_in), .pc_in(pc_in), .iw_in(iw_in),
      .alu_in(alu_in), .rs2_data_in(rs2_data_in), .wb_en_in(wb_en_in), .wb_reg_in(wb_reg_in),
      .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .wb_valid_out(wb_valid_out), .pc_out(pc_out), .iw_out(iw_out), .wb_en_out(wb_en_out),
      .wb_reg_out(wb_reg_out), .wb_data_out(wb_data_out), .err_out(err_out),
      .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Reference model: derives the architectural result of one instruction from its fields.
   task automatic model(input logic [31:0] pc, iw, alu, rs2, rdata, input logic wb_en,
                        input logic [4:0] rd, input int delay,
                        output int is_mem, output exp_t e, output logic [3:0] be,
                        output logic [31:0] wd, output logic [31:0] addr, output logic we);
      logic [6:0] opc;
      logic [2:0] f3;
      int         bytes, lane;
      longint     val;
      logic       ld, st, trap;
      opc   = iw[6:0];
      f3    = iw[14:12];
      ld    = (opc == 7'h03) && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      st    = (opc == 7'h23) && (f3 <= 3'd2);
      bytes = 1 << f3[1:0];
      lane  = int'(alu & 32'd3) - (int'(alu & 32'd3) % bytes);
      trap  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      trap  = (ld || st) && ((int'(alu & 32'd3) % bytes) != 0);
`endif
      e.pc = pc; e.iw = iw; e.rd = rd; e.err = 1'b0; e.cmp_reg = 1'b1; e.cmp_data = 1'b1;
      e.en = wb_en; e.data = alu;
      is_mem = 0; be = 4'hF; wd = '0; we = 1'b0;
      addr = alu & 32'hFFFF_FFFC;
      if (trap) begin
         e.en = 1'b0; e.err = 1'b1; e.cmp_reg = 1'b0; e.cmp_data = 1'b0;
      end else if ((opc == 7'h03 || opc == 7'h23) && !ld && !st) begin
         e.en = 1'b0;
      end else if (ld || st) begin
         is_mem = 1;
         we = st;
         if (st) begin
            be = 4'(((1 << bytes) - 1) << lane);
            if (bytes == 1)      wd = (rs2 & 32'hFF) * 32'h0101_0101;
            else if (bytes == 2) wd = (rs2 & 32'hFFFF) * 32'h0001_0001;
            else                 wd = rs2;
            e.en = 1'b0; e.data = '0; e.cmp_reg = 1'b0;
         end else begin
            val = (longint'(rdata) >> (8 * lane)) & ((64'd1 << (8 * bytes)) - 1);
            if (!f3[2] && bytes < 4 && val >= (64'd1 << (8 * bytes - 1)))
               val = val - (64'd1 << (8 * bytes));
            e.data = val[31:0];
         end
         if (delay < 0) begin
            e.en = 1'b0; e.err = 1'b1; e.cmp_reg = 1'b0; e.cmp_data = 1'b0;
         end
      end
   endtask

   task automatic chk_req(input logic [3:0] be, input logic [31:0] wd, input logic [31:0] addr,
                          input logic we);
      chk("dmem_req", dmem_req, 1);
      chk("dmem_addr", dmem_addr, addr);
      chk("dmem_be", dmem_be, be);
      chk("dmem_we", dmem_we, we);
      if (we) chk("dmem_wdata", dmem_wdata, wd);
   endtask

   // Called at a point just after a rising edge; delay < 0 means memory never acks.
   task automatic do_instr(input logic [31:0] pc, iw, alu, rs2, rdata, input logic wb_en,
                           input logic [4:0] rd, input int delay);
      exp_t        e;
      int          is_mem, waited, stalls;
      logic [3:0]  be;
      logic [31:0] wd, addr;
      logic        we;
      model(pc, iw, alu, rs2, rdata, wb_en, rd, delay, is_mem, e, be, wd, addr, we);
      waited = 0;
      while (stall_out && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      if (stall_out) begin
         checks++; errors++;
         $display("FAIL stall_bound: stall_out still 1 after 20 cycles, expected 0");
      end
      ex_valid_in = 1'b1; pc_in = pc; iw_in = iw; alu_in = alu; rs2_data_in = rs2;
      wb_en_in = wb_en; wb_reg_in = rd;
      exp_q.push_back(e);
      @(posedge clk); #1;
      ex_valid_in = 1'b0;
      if (is_mem == 0) begin
         chk("lat1_valid", wb_valid_out, 1);
         chk("no_req", dmem_req, 0);
         return;
      end
      chk_req(be, wd, addr, we);
      stalls = 0;
      if (delay >= 0) begin
         repeat (delay) begin
            stalls += int'(stall_out);
            @(posedge clk); #1;
            chk_req(be, wd, addr, we);
         end
         stalls += int'(stall_out);
         dmem_ack = 1'b1; dmem_rdata = rdata;
         @(posedge clk); #1;
         dmem_ack = 1'b0; dmem_rdata = $urandom;
         chk("stall_cycles", stalls, delay + 1);
         chk("ack_valid", wb_valid_out, 1);
      end else begin
         repeat (TMO) begin
            stalls += int'(stall_out);
            chk("tmo_req_held", dmem_req, 1);
            @(posedge clk); #1;
         end
         chk("tmo_stall_cycles", stalls, TMO);
         chk("tmo_valid", wb_valid_out, 1);
      end
      chk("req_drop", dmem_req, 0);
      chk("stall_release", stall_out, 0);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (wb_valid_out) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_wb: wb_valid_out=1 pc_out=%h, expected no write-back", pc_out);
            end else begin
               mon_e = exp_q.pop_front();
               chk("wb_pc", pc_out, mon_e.pc);
               chk("wb_iw", iw_out, mon_e.iw);
               chk("wb_en", wb_en_out, mon_e.en);
               chk("wb_err", err_out, mon_e.err);
               chk("df_en", df_mem_enable, mon_e.en && (mon_e.rd != 5'd0));
               if (mon_e.cmp_data) begin
                  chk("wb_data", wb_data_out, mon_e.data);
                  chk("df_data", df_mem_data, mon_e.data);
               end
               if (mon_e.cmp_reg) begin
                  chk("wb_reg", wb_reg_out, mon_e.rd);
                  chk("df_reg", df_mem_reg, mon_e.rd);
               end
               $display("wb pc=%h iw=%h en=%b rd=%0d data=%h err=%b",
                        pc_out, iw_out, wb_en_out, wb_reg_out, wb_data_out, err_out);
            end
         end else begin
            chk("err_idle", err_out, 0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] iw;
      int          r, dly;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", stall_out, 0);
      chk("rst_req", dmem_req, 0);
      chk("rst_valid", wb_valid_out, 0);
      chk("rst_data", wb_data_out, 0);
      chk("rst_err", err_out, 0);
      reset = 1'b0;

      do_instr(32'h1000, 32'h0000_0293, 32'h0000_002A, 32'h0, 32'h0, 1'b1, 5'd5, 0);
      do_instr(32'h1004, 32'h0000_0383, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1'b1, 5'd7, 1);
      do_instr(32'h1008, 32'h0000_4383, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1'b1, 5'd7, 0);
      do_instr(32'h100C, 32'h0000_1023, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 1'b0, 5'd0, 2);
      do_instr(32'h1010, 32'h0000_2383, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 1'b1, 5'd7, 3);
      do_instr(32'h1014, 32'h0000_0293, 32'h0000_0055, 32'h0, 32'h0, 1'b1, 5'd5, 0);
      do_instr(32'h1018, 32'h0000_2383, 32'h0000_0400, 32'h0, 32'h0, 1'b1, 5'd7, -1);

      for (int i = 0; i < 300; i++) begin
         r  = $urandom_range(0, 9);
         iw = $urandom;
         if (r >= 4) iw[6:0] = (r <= 6) ? 7'h03 : 7'h23;
         dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
         do_instr($urandom, iw, $urandom, $urandom, $urandom, 1'($urandom), 5'($urandom), dly);
      end

      // Reset in the second BUSY cycle, then a late ack that must be ignored.
      ex_valid_in = 1'b1; pc_in = 32'h2000; iw_in = 32'h0000_2383; alu_in = 32'h500;
      wb_en_in = 1'b1; wb_reg_in = 5'd7;
      @(posedge clk); #1;
      ex_valid_in = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b1;
      chk("rstbusy_req", dmem_req, 0);
      chk("rstbusy_stall", stall_out, 0);
      chk("rstbusy_valid", wb_valid_out, 0);
      chk("rstbusy_pc", pc_out, 0);
      chk("rstbusy_addr", dmem_addr, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      chk("late_ack_valid", wb_valid_out, 0);
      chk("late_ack_req", dmem_req, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage.
- Consumes the execute result (effective address or ALU value), rs2 store data, destination register and instruction word.
- Performs loads and stores over a req/ack data-memory port and stalls upstream while waiting.
- Registers the write-back value and drives memory-stage forwarding signals.

Parameters:
- TIMEOUT_CYCLES, 255, cycles a request may wait for dmem_ack before it is aborted (1..255).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ex_valid_in  in  1  execute-stage outputs are valid this cycle
- pc_in  in  32  instruction PC
- iw_in  in  32  instruction word
- alu_in  in  32  effective address (load/store) or ALU result
- rs2_data_in  in  32  store data
- wb_en_in  in  1  instruction writes rd
- wb_reg_in  in  5  rd index
- stall_out  out  1  upstream must hold its outputs
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_be  out  4  byte enables
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  request completed; rdata valid
- dmem_rdata  in  32  load word
- wb_valid_out  out  1  write-back bundle valid
- pc_out, iw_out  out  32 each  registered copies
- wb_en_out  out  1  registered write enable
- wb_reg_out  out  5  registered rd
- wb_data_out  out  32  load result or passed ALU value
- err_out  out  1  one-cycle pulse on timeout
- df_mem_enable  out  1  wb_valid_out & wb_en_out & (wb_reg_out != 0)
- df_mem_reg  out  5  = wb_reg_out
- df_mem_data  out  32  = wb_data_out

Behaviour:
- Reset (synchronous): all outputs and registers are 0, state IDLE, timeout counter 0.
- Opcode decode:
  - LOAD 0000011 with funct3 LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - STORE 0100011 with funct3 SB 000, SH 001, SW 010.
  - Any other opcode is a non-memory instruction.
  - Unlisted funct3 under LOAD/STORE is treated as non-memory with wb_en forced to 0.
- FSM:
  - IDLE: stall_out = 0.
    - ex_valid_in with a non-memory op: at the next edge, output registers load the inputs (wb_data_out = alu_in) and wb_valid_out = 1. Latency is 1 cycle.
    - ex_valid_in with a memory op: capture pc, iw, address, data and rd; assert dmem_req; go to BUSY; wb_valid_out = 0.
    - No ex_valid_in: wb_valid_out = 0.
  - BUSY: stall_out = 1 and dmem_* held stable. The counter increments each cycle.
    - dmem_ack = 1: drop dmem_req; write load data, or wb_data_out = 0 with wb_en_out = 0 for stores; wb_valid_out = 1; go to IDLE.
    - The ack cycle itself keeps stall_out = 1. The next instruction is accepted in the following IDLE cycle.
    - Counter reaches TIMEOUT_CYCLES without ack: drop dmem_req; pulse err_out; wb_valid_out = 1 with wb_en_out = 0; go to IDLE.
  - dmem_ack seen in IDLE is ignored.
  - Reset in BUSY: dmem_req = 0 at the next edge; a late ack is ignored.
- Stores:
  - SB: be = 1 << addr[1:0], wdata = byte replicated ×4.
  - SH: be = addr[1] ? 1100 : 0011, wdata = half replicated ×2.
  - SW: be = 1111.
  - dmem_we = 1.
- Loads: dmem_we = 0 and be = 1111. Lane select by addr[1:0], then sign-extend (LB, LH) or zero-extend (LBU, LHU).
- Misalignment (feature off): LH/SH ignore addr[0]; LW/SW ignore addr[1:0].

Optional Feature:
- MEM_MISALIGN_TRAP_EN:
  - Defined: an LH/LHU/SH with addr[0] = 1, or an LW/SW with addr[1:0] != 0, issues no request and stays in IDLE.
  - The next cycle it pulses err_out and drives wb_valid_out = 1 with wb_en_out = 0; pc_out identifies the faulting instruction.
  - Undefined: forced-alignment behaviour as in Behaviour.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants (LOAD, STORE, OP, OP_IMM, JALR);
  - load/store funct3 constants;
  - the state enum {IDLE, BUSY}.
- Sub-module load_extend (combinational): inputs rdata, addr[1:0], funct3; output extended 32-bit value.

Test Plan:
- Non-memory op (alu_in = 0x0000_002A, rd = 5) in IDLE -> next cycle wb_valid_out = 1, wb_data_out = 0x2A, df_mem_enable = 1, df_mem_reg = 5; no dmem_req.
- LB at addr 0x103, rdata = 0x80FF_1234 -> dmem_addr = 0x100, wb_data_out = 0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
- SH at addr 0x202, rs2 = 0x1234_ABCD -> dmem_be = 1100, dmem_wdata = 0xABCD_ABCD, dmem_we = 1, wb_en_out = 0.
- LW with ack delayed 3 cycles -> stall_out high for 4 cycles (3 wait + ack), dmem_* stable, one wb_valid_out pulse; the next instruction completes 2 cycles after ack.
- TIMEOUT_CYCLES = 4, no ack -> dmem_req drops after 4 BUSY cycles, err_out pulses once, wb_en_out = 0.
- Reset asserted in the 2nd BUSY cycle, ack 1 cycle later -> dmem_req = 0 after the edge, no wb_valid_out, all outputs 0.
